bus_xfer_datapath: RTL
======================

Name: bus_xfer_datapath

Overview:
- Parametrised successor of the CPU register/bus datapath: NREG general registers, W-bit shared bus and an encoded source-select bus mux.
- Adds a command-driven transfer sequencer with a valid/ready handshake that executes multi-beat register transfers over the single bus.
- Sits between the control unit (issues commands) and the register file. The ALU, MAR and MDR attach in later revisions.

Parameters:
W, 32, datapath/bus width in bits
NREG, 16, number of general registers (2..64)
CW, 18, width of immediate field; sign-extended to W (as the C constant)
R0_ZERO, 0, 1 = R0 reads as zero and ignores writes
IW (localparam), $clog2(NREG+2), width of source/destination index

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_mode  input  2  00 MOVE, 01 PAIR, 10 SWAP, 11 CLEAR
cmd_src  input  IW  source index: 0..NREG-1 registers, NREG = in_port, NREG+1 = immediate
cmd_dst  input  IW  destination index; registers only
cmd_imm  input  CW  immediate, sign-extended to W
in_port  input  W  external input, sampled in the beat that drives it
done  output  1  one-cycle completion pulse
err  output  1  valid only with done; 1 = command rejected
bus_data  output  W  current bus value; 0 when no beat is active
rd_sel  input  IW  debug read index
rd_data  output  W  combinational read of register rd_sel; 0 if out of range

Behaviour:
- Reset (clr=0, asynchronous): all registers cleared to 0, state goes to IDLE. Outputs: cmd_ready=1 once clr=1, done=0, err=0, bus_data=0.
- A reset mid-command aborts the command. No done pulse is produced and partial writes are lost to the clear.
- States: IDLE, BEAT1, BEAT2, BEAT3, DONE. cmd_ready=1 only in IDLE.
- Accept on a rising edge with cmd_valid&cmd_ready. Command fields are latched at that edge and later input changes are ignored.
- Validation happens at accept. If the command is illegal, go to DONE with err=1 and perform no writes. Illegal cases:
  - dst >= NREG.
  - src > NREG+1.
  - PAIR with src or dst >= NREG-1, or src not a register.
  - SWAP with src not a register.
- Beats: in each beat the bus carries exactly one source value. The destination is written at the edge that ends the beat.
- MOVE: BEAT1 bus=src value, dst<=bus; then DONE.
- CLEAR: BEAT1 bus=0, dst<=0; src is ignored and never makes the command illegal.
- PAIR: BEAT1 dst<=R[src]; BEAT2 dst+1<=R[src+1]. The beat-2 read sees the beat-1 write, e.g. dst=src+1 gives sequential semantics.
- SWAP: BEAT1 tmp<=R[src]; BEAT2 R[src]<=R[dst]; BEAT3 R[dst]<=tmp. src==dst is legal and leaves the value unchanged.
- DONE lasts one cycle: done=1 and err is valid. The next state is IDLE, so back-to-back commands are spaced by at least one IDLE cycle.
- Latency from the accept edge to the done cycle: MOVE/CLEAR done in cycle 2, PAIR 3, SWAP 4, error 1.
- Bus select uses a priority encoder over the one-hot beat source. Exactly one source drives the bus per beat, and an internal assertion flags more than one.
- R0_ZERO=1: writes to R0 complete normally (err=0) but are discarded, and R0 always reads 0.
- Immediate: bus = {{(W-CW){imm[CW-1]}}, imm}.
- rd_data is combinational and reflects register state after the last edge.

Test Plan:
- Reset: load R3=0x1234 via immediate MOVE, pulse clr low mid-SWAP -> all registers 0, no done, cmd_ready=1 after release.
- MOVE immediate: imm=0x20000 (CW=18), dst=5 -> R5=0xFFFE0000, done in cycle 2, err=0. Then src=NREG (in_port=0xCAFEBABE) to dst=6 -> R6=0xCAFEBABE.
- PAIR overlap: R2=0x11, R3=0x22; PAIR src=2, dst=3 -> R3=0x11, R4=0x11 (sequential semantics); done in cycle 3.
- SWAP: R7=0xAAAA, R9=0x5555 -> R7=0x5555, R9=0xAAAA, done in cycle 4. SWAP src=dst=7 -> unchanged.
- Errors: dst=NREG; PAIR src=NREG-1; SWAP src=NREG+1 -> each gives done with err=1 in cycle 1 and all registers unchanged.
- Handshake and R0: cmd_valid held high for 3 commands -> accepts only when cmd_ready=1. With R0_ZERO=1, MOVE imm 5 to dst=0 -> done with err=0 and rd_data(0)=0.

Source files
------------

// File: rtl/bus_xfer_datapath.sv
// Register file on a single shared bus, with a valid/ready command sequencer that
// runs MOVE/PAIR/SWAP/CLEAR as one, two or three bus beats.
module bus_xfer_datapath #(
  parameter int W       = 32,
  parameter int NREG    = 16,
  parameter int CW      = 18,
  parameter int R0_ZERO = 0,
  localparam int IW     = $clog2(NREG + 2)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_mode,
  input  logic [IW-1:0] cmd_src,
  input  logic [IW-1:0] cmd_dst,
  input  logic [CW-1:0] cmd_imm,
  input  logic [W-1:0]  in_port,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  bus_data,
  input  logic [IW-1:0] rd_sel,
  output logic [W-1:0]  rd_data
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic R0Z = (R0_ZERO != 0);

  localparam int SRC_REG  = 0;
  localparam int SRC_PORT = 1;
  localparam int SRC_IMM  = 2;
  localparam int SRC_TMP  = 3;
  localparam int SRC_ZERO = 4;

  typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, BEAT3, DONE} state_e;
  typedef enum logic [1:0] {
    MODE_MOVE  = 2'b00,
    MODE_PAIR  = 2'b01,
    MODE_SWAP  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  state_e        state_q, state_d;
  mode_e         mode_q;
  logic [IW-1:0] src_q;
  logic [IW-1:0] dst_q;
  logic [CW-1:0] imm_q;
  logic          err_q;
  logic [W-1:0]  tmp_q;
  logic [W-1:0]  regs_q [NREG];

  logic          accept;
  logic          cmdIllegal;
  logic [4:0]    beatOh;
  logic [IW-1:0] rdIdx;
  logic [IW-1:0] wrIdx;
  logic          wrEn;
  logic          tmpWr;
  logic [W-1:0]  regRdData;
  logic [W-1:0]  immExt;
  logic [W-1:0]  busVal;

  assign accept = cmd_valid && (state_q == IDLE);
  assign immExt = {{(W-CW){imm_q[CW-1]}}, imm_q};

  // Legality is decided once, from the raw command fields, at the accept edge.
  always_comb begin
    cmdIllegal = 1'b0;
    if (cmd_dst >= IW'(NREG)) cmdIllegal = 1'b1;
    case (mode_e'(cmd_mode))
      MODE_MOVE:  if (cmd_src > IW'(NREG + 1)) cmdIllegal = 1'b1;
      MODE_PAIR:  if ((cmd_src >= IW'(NREG - 1)) || (cmd_dst >= IW'(NREG - 1))) cmdIllegal = 1'b1;
      MODE_SWAP:  if (cmd_src >= IW'(NREG)) cmdIllegal = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = cmdIllegal ? DONE : BEAT1;
      BEAT1: state_d = ((mode_q == MODE_PAIR) || (mode_q == MODE_SWAP)) ? BEAT2 : DONE;
      BEAT2: state_d = (mode_q == MODE_SWAP) ? BEAT3 : DONE;
      BEAT3: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-beat control: which single source drives the bus and where it lands.
  always_comb begin
    beatOh = '0;
    rdIdx  = src_q;
    wrIdx  = dst_q;
    wrEn   = 1'b0;
    tmpWr  = 1'b0;
    unique case (state_q)
      BEAT1: begin
        unique case (mode_q)
          MODE_MOVE: begin
            if (src_q < IW'(NREG))       beatOh[SRC_REG]  = 1'b1;
            else if (src_q == IW'(NREG)) beatOh[SRC_PORT] = 1'b1;
            else                         beatOh[SRC_IMM]  = 1'b1;
            wrEn = 1'b1;
          end
          MODE_CLEAR: begin
            beatOh[SRC_ZERO] = 1'b1;
            wrEn             = 1'b1;
          end
          MODE_PAIR: begin
            beatOh[SRC_REG] = 1'b1;
            wrEn            = 1'b1;
          end
          MODE_SWAP: begin
            beatOh[SRC_REG] = 1'b1;
            tmpWr           = 1'b1;
          end
          default: ;
        endcase
      end
      BEAT2: begin
        beatOh[SRC_REG] = 1'b1;
        wrEn            = 1'b1;
        if (mode_q == MODE_PAIR) begin
          rdIdx = src_q + IW'(1);
          wrIdx = dst_q + IW'(1);
        end else begin
          rdIdx = dst_q;
          wrIdx = src_q;
        end
      end
      BEAT3: begin
        beatOh[SRC_TMP] = 1'b1;
        wrEn            = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    regRdData = '0;
    if ((rdIdx < IW'(NREG)) && !(R0Z && (rdIdx == '0))) regRdData = regs_q[rdIdx[AW-1:0]];
  end

  always_comb begin
    busVal = '0;
    if (beatOh[SRC_REG])       busVal = regRdData;
    else if (beatOh[SRC_PORT]) busVal = in_port;
    else if (beatOh[SRC_IMM])  busVal = immExt;
    else if (beatOh[SRC_TMP])  busVal = tmp_q;
    else                       busVal = '0;
  end

  assert property (@(posedge clk) disable iff (!clr) $onehot0(beatOh));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mode_q <= MODE_MOVE;
      src_q  <= '0;
      dst_q  <= '0;
      imm_q  <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      mode_q <= mode_e'(cmd_mode);
      src_q  <= cmd_src;
      dst_q  <= cmd_dst;
      imm_q  <= cmd_imm;
      err_q  <= cmdIllegal;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tmp_q <= '0;
    end else if (tmpWr) begin
      tmp_q <= busVal;
    end
  end

  // With R0_ZERO set, R0 writes still complete as a beat but are dropped here.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wrEn && (wrIdx < IW'(NREG)) && !(R0Z && (wrIdx == '0))) begin
      regs_q[wrIdx[AW-1:0]] <= busVal;
    end
  end

  always_comb begin
    rd_data = '0;
    if ((rd_sel < IW'(NREG)) && !(R0Z && (rd_sel == '0))) rd_data = regs_q[rd_sel[AW-1:0]];
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) && err_q;
  assign bus_data  = busVal;

endmodule
